// File: rtl/scan_password_keypad_pkg.sv
// Shared constants and small helpers for the scanned password keypad.
// Holds the empty-digit marker, default timing and the frame classification type.
package scan_password_keypad_pkg;

  localparam logic [4:0] EMPTY_DIGIT             = 5'h10;
  localparam int         DEFAULT_SCAN_DIV        = 50000;
  localparam int         DEFAULT_DEBOUNCE_FRAMES = 3;

  typedef enum logic [1:0] {
    FRAME_RELEASED = 2'd0,
    FRAME_SINGLE   = 2'd1,
    FRAME_INVALID  = 2'd2
  } frame_kind_e;

  // Number of active-low (pressed) rows in one column sample.
  function automatic logic [2:0] count_low(input logic [3:0] r);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Index of the lowest pressed row; only meaningful when exactly one is low.
  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_password_keypad_scanner.sv
// Column scanner for a 4x4 keypad: drives one-cold columns, synchronizes rows,
// classifies each full scan frame and debounces into a one-cycle key_valid pulse.
module keypad_scanner
  import scan_password_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_FRAMES = DEFAULT_DEBOUNCE_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_TARGET = STAB_W'(DEBOUNCE_FRAMES);

  logic [3:0]        row_meta;
  logic [3:0]        row_sync;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        col_idx;
  logic [1:0]        acc_cnt;
  logic [3:0]        acc_code;
  logic [STAB_W-1:0] stab_cnt;
  logic [3:0]        prev_code;
  logic              armed;
  logic              key_valid_q;
  logic [3:0]        key_code_q;

  logic              dwell_end;
  logic              frame_end;
  logic [2:0]        col_lows;
  logic [3:0]        col_code;
  logic [1:0]        merged_cnt;
  logic [3:0]        merged_code;
  frame_kind_e       frame_kind;
  logic [STAB_W-1:0] stab_next;
  logic              accept;

  assign col       = ~(4'b0001 << col_idx);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

  // acc_cnt saturates at 2: the frame only cares about none / one / many keys.
  always_comb begin
    dwell_end   = (div_cnt == DIV_LAST);
    frame_end   = dwell_end && (col_idx == 2'd3);
    col_lows    = count_low(row_sync);
    col_code    = {low_index(row_sync), col_idx};
    merged_cnt  = acc_cnt;
    merged_code = acc_code;
    if (col_lows == 3'd1) begin
      if (acc_cnt == 2'd0) begin
        merged_cnt  = 2'd1;
        merged_code = col_code;
      end else begin
        merged_cnt = 2'd2;
      end
    end else if (col_lows > 3'd1) begin
      merged_cnt = 2'd2;
    end

    case (merged_cnt)
      2'd0:    frame_kind = FRAME_RELEASED;
      2'd1:    frame_kind = FRAME_SINGLE;
      default: frame_kind = FRAME_INVALID;
    endcase

    // Counter saturates at the target so long holds cannot wrap into a repeat.
    stab_next = '0;
    if (frame_kind == FRAME_SINGLE) begin
      if (merged_code == prev_code) begin
        stab_next = (stab_cnt == STAB_TARGET) ? stab_cnt : stab_cnt + 1'b1;
      end else begin
        stab_next = STAB_W'(1);
      end
    end
    accept = (frame_kind == FRAME_SINGLE) && (stab_next == STAB_TARGET) && armed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (dwell_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt     <= '0;
      acc_code    <= '0;
      stab_cnt    <= '0;
      prev_code   <= '0;
      armed       <= 1'b1;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end) begin
        acc_cnt  <= '0;
        acc_code <= '0;
        stab_cnt <= stab_next;
        if (frame_kind == FRAME_SINGLE) prev_code <= merged_code;
        if (frame_kind == FRAME_RELEASED) armed <= 1'b1;
        if (accept) begin
          armed       <= 1'b0;
          key_valid_q <= 1'b1;
          key_code_q  <= merged_code;
        end
      end else if (dwell_end) begin
        acc_cnt  <= merged_cnt;
        acc_code <= merged_code;
      end
    end
  end

endmodule

// File: rtl/scan_password_keypad.sv
// Password entry front end: a scanned keypad feeding a four-digit shift register
// (p0 newest) that any of four synchronous clear requests can empty.
module scan_password_keypad
  import scan_password_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_FRAMES = DEFAULT_DEBOUNCE_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst1,
  input  logic       rst2,
  input  logic       rst3,
  input  logic       rst4,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] p0,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic [4:0] p3
);

  logic       key_valid;
  logic [3:0] key_code;
  logic       clear;

  assign clear = rst1 | rst2 | rst3 | rst4;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // Clear wins over a same-cycle key; the scanner has already disarmed itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0 <= EMPTY_DIGIT;
      p1 <= EMPTY_DIGIT;
      p2 <= EMPTY_DIGIT;
      p3 <= EMPTY_DIGIT;
    end else if (clear) begin
      p0 <= EMPTY_DIGIT;
      p1 <= EMPTY_DIGIT;
      p2 <= EMPTY_DIGIT;
      p3 <= EMPTY_DIGIT;
    end else if (key_valid) begin
      p3 <= p2;
      p2 <= p1;
      p1 <= p0;
      p0 <= {1'b0, key_code};
    end
  end

endmodule

// File: tb/tb_scan_password_keypad.sv
// Bench for scan_password_keypad with SCAN_DIV=4, DEBOUNCE_FRAMES=3 and a
// behavioural 4x4 keypad that pulls rows low for held keys in the driven column.
module tb_scan_password_keypad;
  import scan_password_keypad_pkg::*;

  localparam int          FRAME = 16;
  localparam logic [19:0] EMPTY4 = {4{5'h10}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] clr = '0;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] p0, p1, p2, p3;
  logic [15:0] keys = '0;
  logic [19:0] vec;
  logic [19:0] last_vec = EMPTY4;
  logic [19:0] exp_vec  = EMPTY4;
  logic [4:0]  exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  assign vec = {p3, p2, p1, p0};

  scan_password_keypad #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .rst1 (clr[0]),
    .rst2 (clr[1]),
    .rst3 (clr[2]),
    .rst4 (clr[3]),
    .row  (row),
    .col  (col),
    .p0   (p0),
    .p1   (p1),
    .p2   (p2),
    .p3   (p3)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every shift of a new digit into p0 pops one expected digit.
  always @(negedge clk) begin
    if (vec != last_vec && p0 != EMPTY_DIGIT) begin
      if (exp_q.size() == 0) begin
        check("extra_digit", {15'd0, p0}, {15'd0, EMPTY_DIGIT});
      end else begin
        exp_vec = {exp_vec[14:0], exp_q.pop_front()};
        check("digit_shift", vec, exp_vec);
      end
    end
    last_vec = vec;
  end

  task automatic press_key(input int code, input int frames, input bit expect_digit);
    @(negedge clk);
    keys = 16'd1 << code;
    if (expect_digit) exp_q.push_back({1'b0, 4'(code)});
    repeat (frames * FRAME) @(negedge clk);
    keys = '0;
    repeat (2 * FRAME) @(negedge clk);
  endtask

  task automatic pulse_clear(input int idx);
    @(negedge clk);
    clr[idx] = 1'b1;
    exp_vec  = EMPTY4;
    @(negedge clk);
    clr = '0;
    check($sformatf("clear_rst%0d", idx + 1), vec, EMPTY4);
  endtask

  initial begin
    logic [3:0] col_tbl[4];
    bit found;
    col_tbl[0] = 4'b1101;
    col_tbl[1] = 4'b1011;
    col_tbl[2] = 4'b0111;
    col_tbl[3] = 4'b1110;

    repeat (3) @(negedge clk);
    check("reset_col", {16'd0, col}, {16'd0, 4'b1110});
    check("reset_digits", vec, EMPTY4);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("col_step%0d", i), {16'd0, col}, {16'd0, col_tbl[i]});
    end

    // Key at row 1, column 2 held for five frames.
    press_key(6, 5, 1'b1);
    check("single_key_6", vec, {5'h10, 5'h10, 5'h10, 5'h06});

    for (int k = 1; k <= 5; k++) press_key(k, 5, 1'b1);
    check("five_keys", vec, {5'h02, 5'h03, 5'h04, 5'h05});
    pulse_clear(2);

    // Two keys in one column, then a one-frame glitch: neither enters a digit.
    press_key(12, 5, 1'b1);
    @(negedge clk);
    keys = 16'h0011;
    repeat (5 * FRAME) @(negedge clk);
    keys = '0;
    repeat (2 * FRAME) @(negedge clk);
    check("multi_key_ignored", vec, {5'h10, 5'h10, 5'h10, 5'h0C});
    press_key(10, 1, 1'b0);
    check("glitch_ignored", vec, {5'h10, 5'h10, 5'h10, 5'h0C});

    for (int i = 0; i < 4; i++) begin
      press_key((13 + i) % 16, 5, 1'b1);
      pulse_clear(i);
    end

    // Clear held across acceptance; key stays down after clear drops.
    press_key(8, 5, 1'b1);
    @(negedge clk);
    clr[1] = 1'b1;
    exp_vec = EMPTY4;
    keys = 16'd1 << 9;
    repeat (5 * FRAME) @(negedge clk);
    clr = '0;
    repeat (3 * FRAME) @(negedge clk);
    keys = '0;
    repeat (2 * FRAME) @(negedge clk);
    check("clear_beats_press", vec, EMPTY4);

    // Reset in the middle of a frame with a key held.
    press_key(7, 5, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (col == 4'b1011) found = 1'b1;
    end
    check("col_sync_found", {19'd0, found}, 20'd1);
    keys = 16'd1 << 11;
    repeat (FRAME) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midframe_rst_col", {16'd0, col}, {16'd0, 4'b1110});
    check("midframe_rst_digits", vec, EMPTY4);
    exp_vec = EMPTY4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(5'h0B);
    repeat (3 * FRAME) @(negedge clk);
    check("debounce_not_early", vec, EMPTY4);
    @(negedge clk);
    check("debounce_three_frames", vec, {5'h10, 5'h10, 5'h10, 5'h0B});
    repeat (2 * FRAME) @(negedge clk);
    keys = '0;
    repeat (2 * FRAME) @(negedge clk);
    check("held_key_once", vec, {5'h10, 5'h10, 5'h10, 5'h0B});

    check("pending_digits", 20'(exp_q.size()), 20'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
